// File: rtl/grf_write_arbiter.sv
// GRF write-port arbiter: WB stage (A) has priority, MDU results (B) queue in a FIFO with an
// anti-starvation stall. Define GRF_ARB_TRACE_EN to print every committed GRF write.
module grf_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,      // active-low, asynchronous
  input  logic        i_a_valid,
  input  logic [4:0]  i_a_wa,
  input  logic [31:0] i_a_wd,
  input  logic [31:0] i_a_pc,
  output logic        o_a_stall,
  input  logic        i_b_valid,
  output logic        o_b_ready,
  input  logic [4:0]  i_b_wa,
  input  logic [31:0] i_b_wd,
  input  logic [31:0] i_b_pc,
  output logic [31:0] o_b_pending,
  output logic        o_grf_we,
  output logic [4:0]  o_grf_wa,
  output logic [31:0] o_grf_wd,
  output logic [31:0] o_grf_pc
);

  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

  // FIFO storage and bookkeeping
  logic [4:0]       r_fifo_wa [DEPTH];
  logic [31:0]      r_fifo_wd [DEPTH];
  logic [31:0]      r_fifo_pc [DEPTH];
  logic [DEPTH-1:0] r_fifo_vld;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;

  // Starvation FSM
  state_e             r_state;
  logic [StarveW-1:0] r_starve_cnt;
  logic               r_a_stall;

  // Registered GRF outputs
  logic        r_grf_we;
  logic [4:0]  r_grf_wa;
  logic [31:0] r_grf_wd;
  logic [31:0] r_grf_pc;

  logic        w_fifo_empty;
  logic        w_b_ready;
  logic        w_push;
  logic        w_grant_a;
  logic        w_grant_b;
  logic [31:0] w_lose_cnt;
  logic        w_starve_hit;
  logic [4:0]  w_head_wa;
  logic [31:0] w_head_wd;
  logic [31:0] w_head_pc;

  assign w_fifo_empty = (r_count == '0);
  assign w_b_ready    = (r_count != CntW'(DEPTH));
  assign w_push       = i_b_valid && w_b_ready;

  assign w_head_wa = r_fifo_wa[r_rd_ptr];
  assign w_head_wd = r_fifo_wd[r_rd_ptr];
  assign w_head_pc = r_fifo_pc[r_rd_ptr];

  // Losses B would have accumulated if A wins this cycle
  assign w_lose_cnt   = 32'(r_starve_cnt) + 32'd1;
  assign w_starve_hit = (w_lose_cnt >= STARVE_LIMIT);

  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (r_state == StForce) begin
      w_grant_b = !w_fifo_empty;
    end else if (i_a_valid) begin
      w_grant_a = 1'b1;
    end else begin
      w_grant_b = !w_fifo_empty;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_fifo_vld <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr             <= r_wr_ptr + PtrW'(1);
        r_fifo_vld[r_wr_ptr] <= 1'b1;
      end
      // Push and pop never share a slot: that needs count 0 (no pop) or DEPTH (no push)
      if (w_grant_b) begin
        r_rd_ptr             <= r_rd_ptr + PtrW'(1);
        r_fifo_vld[r_rd_ptr] <= 1'b0;
      end
      case ({w_push, w_grant_b})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_wa[r_wr_ptr] <= i_b_wa;
      r_fifo_wd[r_wr_ptr] <= i_b_wd;
      r_fifo_pc[r_wr_ptr] <= i_b_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_starve_cnt <= '0;
      r_a_stall    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_a_stall <= 1'b0;
          if (w_grant_a && !w_fifo_empty) begin
            if (w_starve_hit) begin
              r_state      <= StForce;
              r_starve_cnt <= '0;
              r_a_stall    <= 1'b1;
            end else begin
              r_state      <= StWait;
              r_starve_cnt <= StarveW'(w_lose_cnt);
            end
          end
        end
        StWait: begin
          r_a_stall <= 1'b0;
          if (w_grant_b || w_fifo_empty) begin
            r_state      <= StIdle;
            r_starve_cnt <= '0;
          end else if (w_grant_a) begin
            if (w_starve_hit) begin
              r_state      <= StForce;
              r_starve_cnt <= '0;
              r_a_stall    <= 1'b1;
            end else begin
              r_starve_cnt <= StarveW'(w_lose_cnt);
            end
          end
        end
        StForce: begin
          r_state      <= StIdle;
          r_starve_cnt <= '0;
          r_a_stall    <= 1'b0;
        end
        default: begin
          r_state      <= StIdle;
          r_starve_cnt <= '0;
          r_a_stall    <= 1'b0;
        end
      endcase
    end
  end

  // Writes to $0 are consumed but never reach the GRF
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_grf_we <= 1'b0;
      r_grf_wa <= '0;
      r_grf_wd <= '0;
      r_grf_pc <= '0;
    end else if (w_grant_a) begin
      r_grf_we <= (i_a_wa != '0);
      r_grf_wa <= i_a_wa;
      r_grf_wd <= i_a_wd;
      r_grf_pc <= i_a_pc;
    end else if (w_grant_b) begin
      r_grf_we <= (w_head_wa != '0);
      r_grf_wa <= w_head_wa;
      r_grf_wd <= w_head_wd;
      r_grf_pc <= w_head_pc;
    end else begin
      r_grf_we <= 1'b0;
    end
  end

  always_comb begin
    o_b_pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_fifo_vld[i]) begin
        o_b_pending[r_fifo_wa[i]] = 1'b1;
      end
    end
    o_b_pending[0] = 1'b0;
  end

  assign o_a_stall = r_a_stall;
  assign o_b_ready = w_b_ready;
  assign o_grf_we  = r_grf_we;
  assign o_grf_wa  = r_grf_wa;
  assign o_grf_wd  = r_grf_wd;
  assign o_grf_pc  = r_grf_pc;

`ifdef GRF_ARB_TRACE_EN
  logic r_grf_src_b;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_grf_src_b <= 1'b0;
    end else if (w_grant_a || w_grant_b) begin
      r_grf_src_b <= w_grant_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset && r_grf_we) begin
      $display("%d@%h: $%d <= %h (%s)", $time, r_grf_pc, r_grf_wa, r_grf_wd,
               r_grf_src_b ? "B" : "A");
    end
  end
`else
`endif

  a_valid_during_stall: assert property (@(posedge i_clk) disable iff (!i_reset)
      !(r_a_stall && i_a_valid))
    else $error("grf_write_arbiter: a_valid asserted while a_stall is high");

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Randomized and directed bench for grf_write_arbiter against a queue-based reference model.
module tb_grf_write_arbiter;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 3;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic [31:0] a_pc;
  logic        a_stall;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_wa;
  logic [31:0] b_wd;
  logic [31:0] b_pc;
  logic [31:0] b_pending;
  logic        grf_we;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  int n_pass;
  int n_total;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  // Reference model: B queue, consecutive-loss count, pending stall, GRF port image
  ent_t        m_q[$];
  int          m_lose;
  bit          m_stall;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_pc;

  grf_write_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_a_valid  (a_valid),
    .i_a_wa     (a_wa),
    .i_a_wd     (a_wd),
    .i_a_pc     (a_pc),
    .o_a_stall  (a_stall),
    .i_b_valid  (b_valid),
    .o_b_ready  (b_ready),
    .i_b_wa     (b_wa),
    .i_b_wd     (b_wd),
    .i_b_pc     (b_pc),
    .o_b_pending(b_pending),
    .o_grf_we   (grf_we),
    .o_grf_wa   (grf_wa),
    .o_grf_wd   (grf_wd),
    .o_grf_pc   (grf_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] exp_pending();
    logic [31:0] p;
    p = '0;
    foreach (m_q[i]) begin
      if (m_q[i].wa != 5'd0) p[m_q[i].wa] = 1'b1;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_lose  = 0;
    m_stall = 1'b0;
    m_we    = 1'b0;
    m_wa    = '0;
    m_wd    = '0;
    m_pc    = '0;
  endtask

  task automatic clear_inputs();
    a_valid = 1'b0;
    a_wa    = '0;
    a_wd    = '0;
    a_pc    = '0;
    b_valid = 1'b0;
    b_wa    = '0;
    b_wd    = '0;
    b_pc    = '0;
  endtask

  // Advance model by one clock using the current inputs, then step the DUT past the edge.
  task automatic tick();
    int   sz;
    bit   push;
    bit   ga;
    bit   gb;
    ent_t e;
    sz   = m_q.size();
    push = b_valid && (sz != DEPTH);
    ga   = 1'b0;
    gb   = 1'b0;
    if (m_stall) gb = (sz > 0);
    else if (a_valid) ga = 1'b1;
    else gb = (sz > 0);
    if (ga) begin
      m_we = (a_wa != 5'd0);
      m_wa = a_wa;
      m_wd = a_wd;
      m_pc = a_pc;
    end else if (gb) begin
      m_we = (m_q[0].wa != 5'd0);
      m_wa = m_q[0].wa;
      m_wd = m_q[0].wd;
      m_pc = m_q[0].pc;
    end else begin
      m_we = 1'b0;
    end
    if (ga && sz > 0) begin
      m_lose++;
      if (m_lose >= STARVE_LIMIT) begin
        m_stall = 1'b1;
        m_lose  = 0;
      end else begin
        m_stall = 1'b0;
      end
    end else begin
      m_lose  = 0;
      m_stall = 1'b0;
    end
    if (gb) void'(m_q.pop_front());
    if (push) begin
      e.wa = b_wa;
      e.wd = b_wd;
      e.pc = b_pc;
      m_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (grf_we !== 1'b0) $display("FAIL reset_we: got %b want 0", grf_we); else n_pass++;
    n_total++; if (grf_wa !== 5'd0) $display("FAIL reset_wa: got %0d want 0", grf_wa); else n_pass++;
    n_total++; if (grf_wd !== 32'd0) $display("FAIL reset_wd: got %h want 0", grf_wd); else n_pass++;
    n_total++; if (grf_pc !== 32'd0) $display("FAIL reset_pc: got %h want 0", grf_pc); else n_pass++;
    n_total++; if (b_ready !== 1'b1) $display("FAIL reset_b_ready: got %b want 1", b_ready); else n_pass++;
    n_total++; if (b_pending !== 32'd0) $display("FAIL reset_pending: got %h want 0", b_pending); else n_pass++;
    n_total++; if (a_stall !== 1'b0) $display("FAIL reset_a_stall: got %b want 0", a_stall); else n_pass++;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_a_only();
    a_valid = 1'b1;
    a_wa    = 5'd5;
    a_wd    = 32'h1234;
    a_pc    = 32'h0000_0100;
    tick();
    a_valid = 1'b0;
    n_total++; if (grf_we !== 1'b1) $display("FAIL a_only_we: got %b want 1", grf_we); else n_pass++;
    n_total++; if (grf_wa !== 5'd5) $display("FAIL a_only_wa: got %0d want 5", grf_wa); else n_pass++;
    n_total++; if (grf_wd !== 32'h1234) $display("FAIL a_only_wd: got %h want 1234", grf_wd); else n_pass++;
    n_total++; if (grf_pc !== 32'h100) $display("FAIL a_only_pc: got %h want 100", grf_pc); else n_pass++;
    tick();
    n_total++; if (grf_we !== 1'b0) $display("FAIL a_only_idle_we: got %b want 0", grf_we); else n_pass++;
  endtask

  task automatic test_b_single();
    b_valid = 1'b1;
    b_wa    = 5'd8;
    b_wd    = 32'hCAFE_0008;
    b_pc    = 32'h0000_0200;
    tick();
    b_valid = 1'b0;
    n_total++; if (b_pending !== 32'h100) $display("FAIL b_single_pending: got %h want 100", b_pending); else n_pass++;
    n_total++; if (grf_we !== 1'b0) $display("FAIL b_single_we0: got %b want 0", grf_we); else n_pass++;
    tick();
    n_total++; if (grf_we !== 1'b1) $display("FAIL b_single_we1: got %b want 1", grf_we); else n_pass++;
    n_total++; if (grf_wa !== 5'd8) $display("FAIL b_single_wa: got %0d want 8", grf_wa); else n_pass++;
    n_total++; if (grf_wd !== 32'hCAFE_0008) $display("FAIL b_single_wd: got %h want cafe0008", grf_wd); else n_pass++;
    n_total++; if (b_pending !== 32'd0) $display("FAIL b_single_clear: got %h want 0", b_pending); else n_pass++;
  endtask

  task automatic test_fifo_full();
    logic [4:0] exp_wa [3];
    exp_wa[0] = 5'd11;
    exp_wa[1] = 5'd12;
    exp_wa[2] = 5'd13;
    for (int c = 0; c < 4; c++) begin
      a_valid = 1'b1;
      a_wa    = 5'd3;
      a_wd    = 32'(c);
      b_valid = 1'b1;
      b_wa    = 5'(9 + c);
      b_wd    = $urandom;
      b_pc    = 32'h300 + 32'(4 * c);
      tick();
    end
    a_valid = 1'b0;
    n_total++; if (b_ready !== 1'b0) $display("FAIL full_b_ready: got %b want 0", b_ready); else n_pass++;
    n_total++; if (a_stall !== 1'b1) $display("FAIL full_stall: got %b want 1", a_stall); else n_pass++;
    b_wa = 5'd13;
    b_wd = 32'h0D0D_0D0D;
    tick();
    n_total++; if (a_stall !== 1'b0) $display("FAIL full_stall_drop: got %b want 0", a_stall); else n_pass++;
    n_total++; if (grf_wa !== 5'd9 || grf_we !== 1'b1) $display("FAIL full_force_pop: got we=%b wa=%0d want we=1 wa=9", grf_we, grf_wa); else n_pass++;
    n_total++; if (b_pending !== 32'h1C00) $display("FAIL full_held: got %h want 1c00", b_pending); else n_pass++;
    tick();
    b_valid = 1'b0;
    n_total++; if (grf_wa !== 5'd10) $display("FAIL full_pop10: got %0d want 10", grf_wa); else n_pass++;
    n_total++; if (b_pending !== 32'h3800) $display("FAIL full_accepted: got %h want 3800", b_pending); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (grf_we !== 1'b1 || grf_wa !== exp_wa[i])
        $display("FAIL full_drain%0d: got we=%b wa=%0d want we=1 wa=%0d", i, grf_we, grf_wa, exp_wa[i]);
      else n_pass++;
    end
    tick();
    n_total++; if (grf_we !== 1'b0 || b_pending !== 32'd0) $display("FAIL full_empty: got we=%b pend=%h want 0/0", grf_we, b_pending); else n_pass++;
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 4; c++) begin
      a_valid = 1'b1;
      a_wa    = 5'(1 + c);
      a_wd    = 32'hA000 + 32'(c);
      b_valid = (c == 0);
      b_wa    = 5'd20;
      b_wd    = 32'hB020;
      b_pc    = 32'h400;
      tick();
      if (c == 2) begin
        n_total++; if (a_stall !== 1'b0) $display("FAIL starve_early: got %b want 0", a_stall); else n_pass++;
      end
    end
    n_total++; if (a_stall !== 1'b1) $display("FAIL starve_stall: got %b want 1", a_stall); else n_pass++;
    n_total++; if (grf_wa !== 5'd4) $display("FAIL starve_last_a: got %0d want 4", grf_wa); else n_pass++;
    a_valid = 1'b0;
    tick();
    n_total++; if (grf_we !== 1'b1 || grf_wa !== 5'd20) $display("FAIL starve_b_write: got we=%b wa=%0d want we=1 wa=20", grf_we, grf_wa); else n_pass++;
    n_total++; if (a_stall !== 1'b0) $display("FAIL starve_one_cycle: got %b want 0", a_stall); else n_pass++;
    a_valid = 1'b1;
    a_wa    = 5'd2;
    tick();
    a_valid = 1'b0;
    n_total++; if (grf_we !== 1'b1 || grf_wa !== 5'd2) $display("FAIL starve_resume: got we=%b wa=%0d want we=1 wa=2", grf_we, grf_wa); else n_pass++;
  endtask

  task automatic test_zero_reg();
    a_valid = 1'b1;
    a_wa    = 5'd0;
    a_wd    = 32'hDEAD;
    b_valid = 1'b1;
    b_wa    = 5'd0;
    b_wd    = 32'hBEEF;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    n_total++; if (grf_we !== 1'b0) $display("FAIL zero_a_we: got %b want 0", grf_we); else n_pass++;
    n_total++; if (b_pending !== 32'd0) $display("FAIL zero_pending: got %h want 0", b_pending); else n_pass++;
    tick();
    n_total++; if (grf_we !== 1'b0) $display("FAIL zero_b_we: got %b want 0", grf_we); else n_pass++;
    b_valid = 1'b1;
    b_wa    = 5'd7;
    b_wd    = 32'h7777;
    tick();
    b_valid = 1'b0;
    tick();
    n_total++; if (grf_we !== 1'b1 || grf_wa !== 5'd7) $display("FAIL zero_consumed: got we=%b wa=%0d want we=1 wa=7", grf_we, grf_wa); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      a_valid = !m_stall && ($urandom_range(0, 3) != 0);
      a_wa    = 5'($urandom_range(0, 31));
      a_wd    = $urandom;
      a_pc    = $urandom;
      b_valid = ($urandom_range(0, 1) == 1);
      b_wa    = 5'($urandom_range(0, 31));
      b_wd    = $urandom;
      b_pc    = $urandom;
      tick();
      n_total++; if (grf_we !== m_we) $display("FAIL rand_we@%0d: got %b want %b", c, grf_we, m_we); else n_pass++;
      if (m_we) begin
        n_total++;
        if (grf_wa !== m_wa || grf_wd !== m_wd || grf_pc !== m_pc)
          $display("FAIL rand_data@%0d: got %0d/%h/%h want %0d/%h/%h", c, grf_wa, grf_wd, grf_pc, m_wa, m_wd, m_pc);
        else n_pass++;
      end
      n_total++; if (a_stall !== m_stall) $display("FAIL rand_stall@%0d: got %b want %b", c, a_stall, m_stall); else n_pass++;
      n_total++; if (b_ready !== (m_q.size() != DEPTH)) $display("FAIL rand_ready@%0d: got %b want %b", c, b_ready, m_q.size() != DEPTH); else n_pass++;
      n_total++; if (b_pending !== exp_pending()) $display("FAIL rand_pending@%0d: got %h want %h", c, b_pending, exp_pending()); else n_pass++;
    end
    clear_inputs();
    for (int i = 0; i < DEPTH + 2; i++) tick();
    n_total++; if (b_pending !== 32'd0 || grf_we !== 1'b0) $display("FAIL rand_drain: got pend=%h we=%b want 0/0", b_pending, grf_we); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 4; c++) begin
      a_valid = 1'b1;
      a_wa    = 5'd4;
      a_wd    = 32'h4444;
      b_valid = 1'b1;
      b_wa    = 5'(21 + c);
      b_wd    = $urandom;
      tick();
    end
    clear_inputs();
    n_total++; if (b_ready !== 1'b0 || b_pending !== 32'h01E0_0000) $display("FAIL mid_pre: got rdy=%b pend=%h want 0/01e00000", b_ready, b_pending); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (b_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", b_ready); else n_pass++;
    n_total++; if (b_pending !== 32'd0) $display("FAIL mid_pending: got %h want 0", b_pending); else n_pass++;
    n_total++; if (grf_we !== 1'b0) $display("FAIL mid_we: got %b want 0", grf_we); else n_pass++;
    n_total++; if (a_stall !== 1'b0) $display("FAIL mid_stall: got %b want 0", a_stall); else n_pass++;
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick();
    n_total++; if (grf_we !== 1'b0 || b_pending !== 32'd0) $display("FAIL mid_discard: got we=%b pend=%h want 0/0", grf_we, b_pending); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    model_reset();
    test_reset();
    test_a_only();
    test_b_single();
    test_fifo_full();
    test_starvation();
    test_zero_reg();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
